// File: rtl/spart_driver.sv
// spart_driver: bus-side controller for the SPART serial port.
// Programs the baud-rate divisor after reset or on a br_cfg change, then
// runs an echo loop: read a received byte, wait for the transmitter, write it back.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'h0515,
    parameter logic [15:0] DIV_9600  = 16'h028A,
    parameter logic [15:0] DIV_19200 = 16'h0144,
    parameter logic [15:0] DIV_38400 = 16'h00A1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    input  logic [7:0] rdata,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] wdata,
    output logic       cfg_done,
    output logic [7:0] echo_count
);

    typedef enum logic [2:0] {
        LOAD, CFG_LO, CFG_HI, IDLE, READ, WAIT_TBR, WRITE
    } state_t;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_DB_L = 2'b10;
    localparam logic [1:0] ADDR_DB_H = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  cfg_sel_q, cfg_sel_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  echo_count_q, echo_count_d;
    logic        cfg_done_q, cfg_done_d;
    logic        iocs_q, iocs_d;
    logic        iorw_q, iorw_d;
    logic [1:0]  ioaddr_q, ioaddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] div_sel;

    // Next-state logic, then bus outputs decoded from the next state so they are registered with it.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cfg_sel_d    = cfg_sel_q;
        rx_byte_d    = rx_byte_q;
        echo_count_d = echo_count_q;
        cfg_done_d   = cfg_done_q;

        case (state_q)
            LOAD: begin
                cfg_sel_d = br_cfg;
                state_d   = CFG_LO;
            end
            CFG_LO: state_d = CFG_HI;
            CFG_HI: begin
                cfg_done_d = 1'b1;
                state_d    = IDLE;
            end
            IDLE: begin
                // A baud change wins over pending receive data.
                if (br_cfg != cfg_sel_q) begin
                    cfg_done_d = 1'b0;
                    state_d    = LOAD;
                end else if (rda) begin
                    state_d = READ;
                end
            end
            READ: begin
                rx_byte_d = rdata;
                state_d   = WAIT_TBR;
            end
            WAIT_TBR: if (tbr) state_d = WRITE;
            WRITE: begin
                echo_count_d = echo_count_q + 8'd1;
                state_d      = IDLE;
            end
            default: state_d = LOAD;
        endcase

        // cfg_sel_d is used so CFG_LO sees the value latched in the LOAD cycle.
        case (cfg_sel_d)
            2'b00:   div_sel = DIV_4800;
            2'b01:   div_sel = DIV_9600;
            2'b10:   div_sel = DIV_19200;
            default: div_sel = DIV_38400;
        endcase

        iocs_d   = 1'b0;
        iorw_d   = 1'b1;
        ioaddr_d = ADDR_BUF;
        wdata_d  = wdata_q;
        case (state_d)
            CFG_LO: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_DB_L;
                wdata_d  = div_sel[7:0];
            end
            CFG_HI: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_DB_H;
                wdata_d  = div_sel[15:8];
            end
            READ: iocs_d = 1'b1;
            WRITE: begin
                iocs_d  = 1'b1;
                iorw_d  = 1'b0;
                wdata_d = rx_byte_d;
            end
            default: ;
        endcase
    end

    // State and output registers; reset drops any access in progress immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= LOAD;
            cfg_sel_q    <= 2'b00;
            rx_byte_q    <= 8'h00;
            echo_count_q <= 8'h00;
            cfg_done_q   <= 1'b0;
            iocs_q       <= 1'b0;
            iorw_q       <= 1'b1;
            ioaddr_q     <= ADDR_BUF;
            wdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            cfg_sel_q    <= cfg_sel_d;
            rx_byte_q    <= rx_byte_d;
            echo_count_q <= echo_count_d;
            cfg_done_q   <= cfg_done_d;
            iocs_q       <= iocs_d;
            iorw_q       <= iorw_d;
            ioaddr_q     <= ioaddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign iocs       = iocs_q;
    assign iorw       = iorw_q;
    assign ioaddr     = ioaddr_q;
    assign wdata      = wdata_q;
    assign cfg_done   = cfg_done_q;
    assign echo_count = echo_count_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed testbench for spart_driver: configuration, echo, stall, reconfig, wrap, reset.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic [7:0] rdata;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] wdata;
    logic       cfg_done;
    logic [7:0] echo_count;

    int checks   = 0;
    int failures = 0;

    spart_driver dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .rdata      (rdata),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .wdata      (wdata),
        .cfg_done   (cfg_done),
        .echo_count (echo_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the full bus view {iocs, iorw, ioaddr, wdata, cfg_done, echo_count}.
    task automatic expect_bus(input string name, input logic e_cs, input logic e_rw,
                              input logic [1:0] e_addr, input logic [7:0] e_wd,
                              input logic e_done, input logic [7:0] e_cnt);
        checks++;
        if ({iocs, iorw, ioaddr, wdata, cfg_done, echo_count} !==
            {e_cs, e_rw, e_addr, e_wd, e_done, e_cnt}) begin
            failures++;
            $display("FAIL %s: got cs=%b rw=%b addr=%b wd=%h done=%b cnt=%0d, want cs=%b rw=%b addr=%b wd=%h done=%b cnt=%0d",
                     name, iocs, iorw, ioaddr, wdata, cfg_done, echo_count,
                     e_cs, e_rw, e_addr, e_wd, e_done, e_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rdata = 8'h00;
        tick(); tick();
        expect_bus("reset_values", 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 8'd0);
        rst = 1'b0;
    endtask

    task automatic test_config();
        tick();
        expect_bus("cfg_db_low", 1'b1, 1'b0, 2'b10, 8'h8A, 1'b0, 8'd0);
        tick();
        expect_bus("cfg_db_high", 1'b1, 1'b0, 2'b11, 8'h02, 1'b0, 8'd0);
        tick();
        expect_bus("cfg_done_idle", 1'b0, 1'b1, 2'b00, 8'h02, 1'b1, 8'd0);
        tick();
        expect_bus("idle_quiet", 1'b0, 1'b1, 2'b00, 8'h02, 1'b1, 8'd0);
    endtask

    task automatic test_echo();
        rda = 1'b1; rdata = 8'h5A; tbr = 1'b1;
        tick();
        expect_bus("echo_read", 1'b1, 1'b1, 2'b00, 8'h02, 1'b1, 8'd0);
        rda = 1'b0;
        tick();
        rdata = 8'h00;
        expect_bus("echo_wait", 1'b0, 1'b1, 2'b00, 8'h02, 1'b1, 8'd0);
        tick();
        expect_bus("echo_write", 1'b1, 1'b0, 2'b00, 8'h5A, 1'b1, 8'd0);
        tick();
        expect_bus("echo_count1", 1'b0, 1'b1, 2'b00, 8'h5A, 1'b1, 8'd1);
    endtask

    task automatic test_tbr_stall();
        int stall_bad = 0;
        tbr = 1'b0; rda = 1'b1; rdata = 8'hC3;
        tick();
        expect_bus("stall_read", 1'b1, 1'b1, 2'b00, 8'h5A, 1'b1, 8'd1);
        rda = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 0) rdata = 8'h00;
            if (iocs !== 1'b0) stall_bad++;
        end
        checks++;
        if (stall_bad !== 0) begin
            failures++;
            $display("FAIL stall_iocs: iocs high in %0d of 50 cycles, want 0", stall_bad);
        end
        tbr = 1'b1;
        tick();
        expect_bus("stall_write", 1'b1, 1'b0, 2'b00, 8'hC3, 1'b1, 8'd1);
        tick();
        expect_bus("stall_count2", 1'b0, 1'b1, 2'b00, 8'hC3, 1'b1, 8'd2);
    endtask

    task automatic test_reconfig();
        tbr = 1'b0; rda = 1'b1; rdata = 8'h11;
        tick();
        expect_bus("recfg_read", 1'b1, 1'b1, 2'b00, 8'hC3, 1'b1, 8'd2);
        rda = 1'b0;
        tick();
        br_cfg = 2'b11;
        tick();
        expect_bus("recfg_hold_wait", 1'b0, 1'b1, 2'b00, 8'hC3, 1'b1, 8'd2);
        tbr = 1'b1;
        tick();
        expect_bus("recfg_echo_first", 1'b1, 1'b0, 2'b00, 8'h11, 1'b1, 8'd2);
        tick();
        expect_bus("recfg_idle", 1'b0, 1'b1, 2'b00, 8'h11, 1'b1, 8'd3);
        tick();
        expect_bus("recfg_load", 1'b0, 1'b1, 2'b00, 8'h11, 1'b0, 8'd3);
        tick();
        expect_bus("recfg_db_low", 1'b1, 1'b0, 2'b10, 8'hA1, 1'b0, 8'd3);
        tick();
        expect_bus("recfg_db_high", 1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 8'd3);
        tick();
        expect_bus("recfg_done", 1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 8'd3);
    endtask

    task automatic test_wrap();
        logic [7:0] exp_cnt = 8'd3;
        logic [7:0] data;
        int wd_bad = 0;
        tbr = 1'b1;
        for (int i = 0; i < 253; i++) begin
            data = 8'(i * 7 + 1);
            rda = 1'b1; rdata = data;
            tick();
            rda = 1'b0;
            tick();
            rdata = ~data;
            tick();
            if (iocs !== 1'b1 || iorw !== 1'b0 || wdata !== data) wd_bad++;
            tick();
            exp_cnt = exp_cnt + 8'd1;
            if (i == 251) begin
                checks++;
                if (echo_count !== 8'd255) begin
                    failures++;
                    $display("FAIL wrap_255: got %0d want 255", echo_count);
                end
            end
        end
        checks++;
        if (wd_bad !== 0) begin
            failures++;
            $display("FAIL wrap_writes: %0d bad write strobes, want 0", wd_bad);
        end
        checks++;
        if (echo_count !== exp_cnt || echo_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap_zero: got %0d want 0", echo_count);
        end
    endtask

    task automatic test_reset_mid_read();
        rda = 1'b1; rdata = 8'h77;
        tick();
        expect_bus("midrst_read", 1'b1, 1'b1, 2'b00, wdata, 1'b1, 8'd0);
        rda = 1'b0;
        #1 rst = 1'b1;
        #1;
        expect_bus("midrst_async", 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 8'd0);
        #1 rst = 1'b0;
        tick();
        expect_bus("midrst_db_low", 1'b1, 1'b0, 2'b10, 8'hA1, 1'b0, 8'd0);
        tick();
        expect_bus("midrst_db_high", 1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 8'd0);
        tick();
        expect_bus("midrst_done", 1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 8'd0);
    endtask

    initial begin
        #2;
        test_reset();
        test_config();
        test_echo();
        test_tbr_stall();
        test_reconfig();
        test_wrap();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Bus-side controller for the SPART (serial port) block, instantiated beside it in top_level.
- After reset, and whenever br_cfg changes, it programs the SPART divisor buffer with the divisor for the selected baud rate.
- It then runs an echo loop: it polls receive-data-available (rda), reads the received byte, waits for transmit-buffer-ready (tbr) and writes the byte back for transmission.
- All SPART register accesses are single-cycle strobes on a split read/write bus.

Parameters:
- DIV_4800, 16'h0515, divisor for br_cfg=2'b00 (100 MHz clock, 16x oversampling)
- DIV_9600, 16'h028A, divisor for br_cfg=2'b01
- DIV_19200, 16'h0144, divisor for br_cfg=2'b10
- DIV_38400, 16'h00A1, divisor for br_cfg=2'b11

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- br_cfg  input  2  baud-rate select
- rda  input  1  SPART receive byte available
- tbr  input  1  SPART transmit buffer ready
- rdata  input  8  SPART read data, valid in the cycle iocs=1 and iorw=1
- iocs  output  1  chip-select strobe, one cycle per access
- iorw  output  1  1=read, 0=write
- ioaddr  output  2  register address: 00=TX/RX buffer, 01=status, 10=DB low, 11=DB high
- wdata  output  8  write data, valid while iocs=1 and iorw=0
- cfg_done  output  1  high once the divisor is programmed and the FSM is in the echo loop
- echo_count  output  8  number of bytes echoed, wraps 255->0

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - state=LOAD, iocs=0, iorw=1, ioaddr=2'b00, wdata=8'h00
  - cfg_done=0, echo_count=0, cfg_sel=2'b00, rx_byte=8'h00
- All outputs are registered and decoded from the current state. No combinational path from any input to any output.
- FSM states and transitions:
  - LOAD: cfg_sel<=br_cfg; outputs idle (iocs=0). Next state CFG_LO.
  - CFG_LO: iocs=1, iorw=0, ioaddr=10, wdata=DIV[cfg_sel][7:0]. Next state CFG_HI.
  - CFG_HI: iocs=1, iorw=0, ioaddr=11, wdata=DIV[cfg_sel][15:8]. Next state IDLE; cfg_done<=1.
  - IDLE: iocs=0.
    - If br_cfg!=cfg_sel: go to LOAD and set cfg_done<=0. This has priority over rda.
    - Else if rda=1: go to READ.
    - Else stay in IDLE.
  - READ: iocs=1, iorw=1, ioaddr=00; rx_byte<=rdata at the end of this cycle. Next state WAIT_TBR.
  - WAIT_TBR: iocs=0; stay until tbr=1, then go to WRITE.
  - WRITE: iocs=1, iorw=0, ioaddr=00, wdata=rx_byte; echo_count<=echo_count+1 (mod 256). Next state IDLE.
- In non-access states iorw=1 and ioaddr=00; wdata holds its last value.
- Latency:
  - Reset release to first DB write: 2 cycles (LOAD, then CFG_LO).
  - rda rising to read strobe: 1 cycle.
  - tbr high in WAIT_TBR to write strobe: 1 cycle.
  - Minimum echo, rda to write strobe: 3 cycles.
- br_cfg change mid-echo (READ, WAIT_TBR or WRITE): the echo completes first. Reconfiguration starts on the IDLE check that follows.
- br_cfg change during LOAD, CFG_LO or CFG_HI: the current programming uses the cfg_sel already latched. The mismatch is then caught in IDLE and triggers a second programming pass.
- rda held high after READ: the SPART clears rda on the read. The FSM only re-evaluates rda in IDLE, so there is no double read within one echo.
- Reset asserted mid-operation: the FSM returns to LOAD asynchronously and iocs drops immediately. No partial access completes.
- Exactly one iocs strobe per access state; iocs is never high for two consecutive cycles except CFG_LO followed by CFG_HI.

Test Plan:
- Reset release with br_cfg=01:
  - Cycle 2: iocs=1, iorw=0, ioaddr=10, wdata=8'h8A.
  - Cycle 3: ioaddr=11, wdata=8'h02.
  - Cycle 4: cfg_done=1.
- Echo: pulse rda with rdata=8'h5A, tbr=1.
  - Read strobe (ioaddr=00, iorw=1) 1 cycle after rda.
  - Write strobe with wdata=8'h5A 2 cycles later.
  - echo_count=1.
- tbr low for 50 cycles after a read of 8'hC3:
  - FSM holds in WAIT_TBR with iocs=0.
  - Write of 8'hC3 occurs 1 cycle after tbr rises.
- br_cfg 01->11 while in WAIT_TBR:
  - Echo write completes first.
  - Then cfg_done=0, and writes 8'hA1 to address 10 and 8'h00 to address 11.
  - cfg_done returns to 1.
- 256 echoes: echo_count wraps to 0.
- Assert rst during READ: iocs=0 immediately, echo_count=0; after release, the DB writes repeat.
